// File: rtl/red_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : red_iter_unit
// Purpose  : Iterative valid/ready bitwise reducer (AND/OR/XOR/XNOR),
//            folding `chunk` bits per cycle with optional AND/OR early exit.
// Revision : 1.0 - initial release
// ============================================================================
module red_iter_unit #(
  parameter int width      = 64,
  parameter int chunk      = 8,
  parameter bit early_exit = 1'b1,
  localparam int N  = (width + chunk - 1) / chunk,
  localparam int CW = $clog2(N + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [width-1:0] A_i,
  input  logic [1:0]       Op_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             Z_o,
  output logic [CW-1:0]    Beats_o
);

  localparam int PW = N * chunk;
  // Bits of the padded operand that lie beyond the real vector.
  localparam logic [PW-1:0] PAD_MASK = ~({PW{1'b1}} >> (PW - width));

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   vec;
  logic [1:0]      op;
  logic            acc;
  logic [CW-1:0]   k;

  logic [chunk-1:0] slice;
  logic             slice_red;
  logic             acc_nxt;
  logic             last_beat;
  logic             early_hit;
  logic             finish;
  logic             accept;

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign accept  = valid_i && (state == IDLE);

  // The captured vector shifts down each beat, so the current chunk is
  // always at the bottom.
  assign slice = vec[chunk-1:0];

  always_comb begin
    slice_red = 1'b0;
    acc_nxt   = 1'b0;
    case (op)
      OP_AND: begin
        slice_red = &slice;
        acc_nxt   = acc & slice_red;
      end
      OP_OR: begin
        slice_red = |slice;
        acc_nxt   = acc | slice_red;
      end
      default: begin
        slice_red = ^slice;
        acc_nxt   = acc ^ slice_red;
      end
    endcase
  end

  assign last_beat = (k == CW'(N - 1));
  assign early_hit = early_exit &&
                     (((op == OP_AND) && !acc_nxt) || ((op == OP_OR) && acc_nxt));
  assign finish    = last_beat || early_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i)  state_nxt = RUN;
      RUN:     if (finish)   state_nxt = DONE;
      DONE:    if (ready_i)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vec     <= '0;
      op      <= '0;
      acc     <= 1'b0;
      k       <= '0;
      Z_o     <= 1'b0;
      Beats_o <= '0;
    end else begin
      if (accept) begin
        // AND padding is filled with ones so the partial chunk stays neutral;
        // zero padding is already neutral for OR/XOR/XNOR.
        vec <= (Op_i == OP_AND) ? (PW'(A_i) | PAD_MASK) : PW'(A_i);
        op  <= Op_i;
        acc <= (Op_i == OP_AND);
        k   <= '0;
      end else if (state == RUN) begin
        acc <= acc_nxt;
        vec <= vec >> chunk;
        k   <= k + CW'(1);
        if (finish) begin
          Z_o     <= (op == OP_XNOR) ? ~acc_nxt : acc_nxt;
          Beats_o <= k + CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_red_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_red_iter_unit
// Purpose  : Directed bench for red_iter_unit over three configurations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_red_iter_unit;

  localparam logic [1:0] AND_OP  = 2'b00;
  localparam logic [1:0] OR_OP   = 2'b01;
  localparam logic [1:0] XOR_OP  = 2'b10;
  localparam logic [1:0] XNOR_OP = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  vi;
  logic [2:0]  ri;
  logic [15:0] ain [3];
  logic [1:0]  opi [3];
  logic        ro0, ro1, ro2, vo0, vo1, vo2, z0, z1, z2;
  logic [2:0]  b0, b1;
  logic [1:0]  b2;

  int total = 0;
  int bad   = 0;

  // d0: 16/4 early exit, d1: 16/4 no early exit, d2: 10/4 early exit
  red_iter_unit #(.width(16), .chunk(4), .early_exit(1'b1)) d0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[0]), .ready_o(ro0),
    .A_i(ain[0]), .Op_i(opi[0]), .valid_o(vo0), .ready_i(ri[0]),
    .Z_o(z0), .Beats_o(b0));

  red_iter_unit #(.width(16), .chunk(4), .early_exit(1'b0)) d1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[1]), .ready_o(ro1),
    .A_i(ain[1]), .Op_i(opi[1]), .valid_o(vo1), .ready_i(ri[1]),
    .Z_o(z1), .Beats_o(b1));

  red_iter_unit #(.width(10), .chunk(4), .early_exit(1'b1)) d2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[2]), .ready_o(ro2),
    .A_i(ain[2][9:0]), .Op_i(opi[2]), .valid_o(vo2), .ready_i(ri[2]),
    .Z_o(z2), .Beats_o(b2));

  function automatic logic get_vo(int d);
    return (d == 0) ? vo0 : (d == 1) ? vo1 : vo2;
  endfunction
  function automatic logic get_ro(int d);
    return (d == 0) ? ro0 : (d == 1) ? ro1 : ro2;
  endfunction
  function automatic logic get_z(int d);
    return (d == 0) ? z0 : (d == 1) ? z1 : z2;
  endfunction
  function automatic logic [2:0] get_b(int d);
    return (d == 0) ? b0 : (d == 1) ? b1 : {1'b0, b2};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Present one request, scramble the inputs after accept, wait for valid_o.
  task automatic issue(input int d, input logic [15:0] a, input logic [1:0] op,
                       input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    vi[d] = 1'b1; ain[d] = a; opi[d] = op;
    @(posedge clk); #1;
    vi[d] = 1'b0; ain[d] = ~a; opi[d] = ~op;
    chk({tag, "_ready_busy"}, get_ro(d), 0);
    lat = 0;
    while (!get_vo(d) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic result(input int d, input logic exp_z, input int exp_b,
                        input string tag);
    chk({tag, "_valid"}, get_vo(d), 1);
    chk({tag, "_z"}, get_z(d), exp_z);
    chk({tag, "_beats"}, get_b(d), exp_b);
  endtask

  task automatic drain(input int d, input string tag);
    ri[d] = 1'b1;
    @(posedge clk); #1;
    ri[d] = 1'b0;
    chk({tag, "_valid_drop"}, get_vo(d), 0);
    chk({tag, "_ready_back"}, get_ro(d), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    vi = '0; ri = '0;
    for (int i = 0; i < 3; i++) begin
      ain[i] = '0; opi[i] = '0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", get_ro(d), 1);
      chk("rst_valid", get_vo(d), 0);
      chk("rst_z", get_z(d), 0);
      chk("rst_beats", get_b(d), 0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Full AND run, then early exit versus no early exit
    issue(0, 16'hFFFF, AND_OP, 4, "and_ones");     result(0, 1'b1, 4, "and_ones");   drain(0, "and_ones");
    issue(0, 16'hFFF0, AND_OP, 1, "and_early");    result(0, 1'b0, 1, "and_early");  drain(0, "and_early");
    issue(1, 16'hFFF0, AND_OP, 4, "and_noearly");  result(1, 1'b0, 4, "and_noearly"); drain(1, "and_noearly");

    // Parity and OR early exit
    issue(0, 16'h0001, XOR_OP, 4, "xor1");   result(0, 1'b1, 4, "xor1");  drain(0, "xor1");
    issue(0, 16'h0001, XNOR_OP, 4, "xnor1"); result(0, 1'b0, 4, "xnor1"); drain(0, "xnor1");
    issue(0, 16'h0100, OR_OP, 3, "or_mid");  result(0, 1'b1, 3, "or_mid"); drain(0, "or_mid");
    issue(1, 16'h0100, OR_OP, 4, "or_full"); result(1, 1'b1, 4, "or_full"); drain(1, "or_full");

    // Partial last chunk (width 10, N=3)
    issue(2, 16'h03FF, AND_OP, 3, "pad_and");  result(2, 1'b1, 3, "pad_and");  drain(2, "pad_and");
    issue(2, 16'h0000, OR_OP, 3, "pad_or");    result(2, 1'b0, 3, "pad_or");   drain(2, "pad_or");
    issue(2, 16'h01FF, AND_OP, 3, "pad_and0"); result(2, 1'b0, 3, "pad_and0"); drain(2, "pad_and0");
    issue(2, 16'h0200, OR_OP, 3, "pad_or1");   result(2, 1'b1, 3, "pad_or1");  drain(2, "pad_or1");
    issue(2, 16'h03FF, XOR_OP, 3, "pad_xor");  result(2, 1'b0, 3, "pad_xor");  drain(2, "pad_xor");

    // Backpressure: result holds while inputs churn
    issue(0, 16'h0070, XOR_OP, 4, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vi[0] = ~vi[0]; ain[0] = 16'($urandom);
      @(posedge clk); #1;
      result(0, 1'b1, 4, "bp_hold");
      chk("bp_ready", get_ro(0), 0);
    end
    @(negedge clk); vi[0] = 1'b0;
    drain(0, "bp");
    chk("bp_z_kept", get_z(0), 1);
    chk("bp_beats_kept", get_b(0), 4);

    // Reset pulse after two beats of a four-beat run
    @(negedge clk);
    vi[0] = 1'b1; ain[0] = 16'hFFFF; opi[0] = AND_OP;
    @(posedge clk); #1; vi[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", get_ro(0), 1);
    chk("abort_valid", get_vo(0), 0);
    chk("abort_z", get_z(0), 0);
    chk("abort_beats", get_b(0), 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_valid_hold", get_vo(0), 0);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_result", get_vo(0), 0);
    end
    issue(0, 16'h8000, XOR_OP, 4, "post_rst"); result(0, 1'b1, 4, "post_rst"); drain(0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/red_iter_unit.md
Name: red_iter_unit

Overview:
Iterative, handshaked bitwise reduction unit: the parametrised successor to the combinational AND reducer. It reduces a wide vector with a runtime-selected operator (AND/OR/XOR/XNOR) over several cycles, folding `chunk` bits per cycle. This trades latency for a narrow reduction tree, with optional early termination. It sits between a producer and a consumer using valid/ready handshakes on both sides.

Parameters:
width, 64, input vector width in bits; must be >= 1.
chunk, 8, bits folded per cycle; must satisfy 1 <= chunk <= width.
early_exit, 1, 1 = finish as soon as an AND/OR result is determined; 0 = always run all beats.
Derived: N = ceil(width/chunk) beats; CW = log2floor(N)+1 bits for the beat counter and Beats_o.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous reset, active-low.
valid_i  in  1  input request valid.
ready_o  out  1  unit can accept a request.
A_i  in  width  vector to reduce.
Op_i  in  2  00 AND, 01 OR, 10 XOR, 11 XNOR.
valid_o  out  1  result valid.
ready_i  in  1  consumer accepts the result.
Z_o  out  1  reduction result.
Beats_o  out  CW  number of beats consumed for the current result (1..N).

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, valid_o=0, Z_o=0, Beats_o=0, and the counter, accumulator and captured operands are cleared. ready_o=1 whenever in IDLE, including during reset.
- ready_o = (state == IDLE), generated combinationally from state only; never from valid_i.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On valid_i & ready_o at edge t0, capture A_i and Op_i.
  - Set the accumulator to the operator identity: AND=1, OR/XOR/XNOR=0.
  - Set the beat counter k=0 and go to RUN.
  - Without valid_i, stay in IDLE.
- RUN:
  - Each edge folds chunk k, bits [k*chunk +: chunk], into the accumulator with the base operator. XNOR uses XOR internally.
  - Bits at index >= width (last partial chunk) are treated as the identity value, so they never affect the result.
  - Then k increments.
- RUN -> DONE transition:
  - Normally at the edge folding chunk N-1, so valid_o rises N cycles after the accept edge.
  - Early exit (early_exit=1): if after folding chunk k the AND accumulator is 0, or the OR accumulator is 1, go to DONE at that edge; valid_o rises k+1 cycles after accept.
  - XOR/XNOR never exit early.
- At DONE entry, register the outputs:
  - Z_o = accumulator value; for XNOR, Z_o = inverted accumulator.
  - Beats_o = beats folded.
- DONE:
  - valid_o=1, and Z_o/Beats_o hold stable until valid_o & ready_i.
  - On the handshake edge, go to IDLE and drop valid_o. Z_o/Beats_o keep their last value.
  - While in DONE, the unit ignores valid_i (ready_o=0). The next request can be accepted at the earliest one cycle after the output handshake.
- Throughput: one request per (beats + 2) cycles at best.
- N=1 (chunk == width): a single RUN beat; equivalent to a registered combinational reduction.
- A_i/Op_i changes after the accept edge have no effect on the operation in flight.
- Reset asserted in RUN or DONE aborts the operation immediately: valid_o=0, state IDLE, no result is emitted.

Test Plan:
1. width=16, chunk=4, early_exit=1; accept A_i=16'hFFFF, Op=AND at t0 -> valid_o high after edge t0+4, Z_o=1, Beats_o=4.
2. Same config; A_i=16'hFFF0, Op=AND -> valid_o after edge t0+1, Z_o=0, Beats_o=1. Repeat with early_exit=0 -> Z_o=0, Beats_o=4.
3. A_i=16'h0001: Op=XOR -> Z_o=1, Beats_o=4; Op=XNOR -> Z_o=0. A_i=16'h0100, Op=OR -> Z_o=1, Beats_o=3.
4. width=10, chunk=4 (N=3); A_i=10'h3FF, Op=AND -> Z_o=1, Beats_o=3 (padding is neutral). A_i=10'h000, Op=OR -> Z_o=0, Beats_o=3.
5. Backpressure: hold ready_i=0 for 5 cycles in DONE while toggling valid_i and A_i -> valid_o stays 1, Z_o/Beats_o stay stable, ready_o stays 0. On ready_i=1: IDLE next cycle, with ready_o=1 and valid_o=0.
6. Pulse rst_ni low mid-RUN (after beat 2 of 4) -> valid_o stays 0 and ready_o=1 immediately. A new request afterwards, A_i=16'h8000, Op=XOR, gives Z_o=1 with no residue from the aborted operation.
